// File: rtl/cdc_req_arbiter_if.sv
// Handshake bundle between the requesters / far-domain ack and the CDC request arbiter.
// The requester side is the master; the arbiter is the slave.
interface cdc_req_arbiter_if #(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4,
    parameter int IDW       = 2
);
    logic [NREQ-1:0]           req;
    logic [NREQ*DATAWIDTH-1:0] req_data;
    logic [NREQ-1:0]           grant;
    logic [DATAWIDTH-1:0]      xfer_data;
    logic [IDW-1:0]            xfer_id;
    logic                      xfer_toggle;
    logic                      ack_toggle;
    logic                      busy;
    logic                      done;
    logic [IDW-1:0]            done_id;
    logic                      ack_err;

    modport master (
        output req, req_data, ack_toggle,
        input  grant, xfer_data, xfer_id, xfer_toggle, busy, done, done_id, ack_err
    );

    modport slave (
        input  req, req_data, ack_toggle,
        output grant, xfer_data, xfer_id, xfer_toggle, busy, done, done_id, ack_err
    );
endinterface

// File: rtl/cdc_req_arbiter.sv
// Source-side CDC launcher: arbitrates requesters, holds the winner's word, toggles a request and
// waits for the synchronized ack toggle. Define CDC_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module cdc_req_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4,
    parameter int IDW       = 2
) (
    input  logic              clk,
    input  logic              rst,
    cdc_req_arbiter_if.slave  bus
);
    localparam int NSLOT = 1 << IDW;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t               state_q;
    logic                 s0_q, s1_q, s2_q;
    logic                 ack_event;
    logic [NREQ-1:0]      grant_q;
    logic [NREQ-1:0]      grant_d;
    logic [DATAWIDTH-1:0] xfer_data_q;
    logic [IDW-1:0]       xfer_id_q;
    logic                 xfer_tog_q;
    logic                 busy_q;
    logic                 done_q;
    logic [IDW-1:0]       done_id_q;
    logic                 ack_err_q;

    logic [DATAWIDTH-1:0] word [NREQ];
    logic [NSLOT-1:0]     req_ext;
    logic [IDW-1:0]       win_idx;
    logic                 win_found;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_word
        assign word[gi] = bus.req_data[gi*DATAWIDTH +: DATAWIDTH];
    end

    // Pad the request vector to a power of two so any IDW-wide index is in range.
    assign req_ext   = NSLOT'(bus.req);
    assign ack_event = s1_q ^ s2_q;

`ifdef CDC_ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] ptr_q;
    logic [IDW:0]   cand;

    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!win_found && req_ext[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDW-1:0];
            end
        end
    end
`else
    // Scanning downward lets the lowest set index overwrite any higher one.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_ext[IDW'(k)]) begin
                win_found = 1'b1;
                win_idx   = IDW'(k);
            end
        end
    end
`endif

    assign grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            s0_q        <= 1'b0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            grant_q     <= '0;
            xfer_data_q <= '0;
            xfer_id_q   <= '0;
            xfer_tog_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            ack_err_q   <= 1'b0;
`ifdef CDC_ARB_ROUND_ROBIN_EN
            ptr_q       <= IDW'(NREQ - 1);
`endif
        end else begin
            s0_q    <= bus.ack_toggle;
            s1_q    <= s0_q;
            s2_q    <= s1_q;
            grant_q <= '0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ack_event) begin
                        ack_err_q <= 1'b1;
                    end
                    if (win_found) begin
                        xfer_data_q <= word[win_idx];
                        xfer_id_q   <= win_idx;
                        xfer_tog_q  <= ~xfer_tog_q;
                        grant_q     <= grant_d;
                        busy_q      <= 1'b1;
                        state_q     <= WAIT_ACK;
`ifdef CDC_ARB_ROUND_ROBIN_EN
                        ptr_q       <= win_idx;
`endif
                    end
                end
                WAIT_ACK: begin
                    if (ack_event) begin
                        done_q    <= 1'b1;
                        done_id_q <= xfer_id_q;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.xfer_data   = xfer_data_q;
    assign bus.xfer_id     = xfer_id_q;
    assign bus.xfer_toggle = xfer_tog_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.done_id     = done_id_q;
    assign bus.ack_err     = ack_err_q;
endmodule

// File: tb/tb_cdc_req_arbiter.sv
// Randomized self-checking bench for cdc_req_arbiter against a transaction-level model
// of arbitration, launch and ack latency.
module tb_cdc_req_arbiter;
    localparam int DW   = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cdc_req_arbiter_if #(.DATAWIDTH(DW), .NREQ(NREQ), .IDW(IDW)) bus ();

    cdc_req_arbiter #(.DATAWIDTH(DW), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   rr_ptr = NREQ - 1;
    logic exp_tog = 1'b0;
    logic exp_ack_err = 1'b0;
    logic ack_tog = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference arbitration: first requester after the last winner (round robin) or lowest index.
    function automatic int pick(input logic [NREQ-1:0] r);
`ifdef CDC_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(rr_ptr + k) % NREQ]) return (rr_ptr + k) % NREQ;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            if (r[k]) return k;
        end
`endif
        return -1;
    endfunction

    task automatic reset_model();
        rr_ptr         = NREQ - 1;
        exp_tog        = 1'b0;
        exp_ack_err    = 1'b0;
        ack_tog        = 1'b0;
        bus.ack_toggle = 1'b0;
    endtask

    task automatic flip_ack();
        ack_tog        = ~ack_tog;
        bus.ack_toggle = ack_tog;
    endtask

    // One request/launch/ack cycle; dly = idle cycles between launch and the far-side ack flip.
    task automatic launch_and_ack(input logic [NREQ-1:0] r, input int dly);
        int w;
        logic [DW-1:0] wd;
        bus.req = r;
        w = pick(r);
        wd = (w >= 0) ? bus.req_data[w*DW +: DW] : '0;
        tick();
        if (w < 0) begin
            check_val("idle_grant", 32'(bus.grant), 32'd0);
            check_val("idle_busy", 32'(bus.busy), 32'd0);
            $display("req=%b no launch", r);
            return;
        end
        exp_tog = ~exp_tog;
`ifdef CDC_ARB_ROUND_ROBIN_EN
        rr_ptr = w;
`endif
        check_val("grant", 32'(bus.grant), 32'(1) << w);
        check_val("xfer_id", 32'(bus.xfer_id), 32'(w));
        check_val("xfer_data", 32'(bus.xfer_data), 32'(wd));
        check_val("xfer_toggle", 32'(bus.xfer_toggle), 32'(exp_tog));
        check_val("busy_launch", 32'(bus.busy), 32'd1);
        bus.req      = NREQ'($urandom);
        bus.req_data = $urandom;
        for (int i = 0; i < dly; i++) begin
            tick();
            check_val("wait_grant", 32'(bus.grant), 32'd0);
            check_val("wait_busy", 32'(bus.busy), 32'd1);
            check_val("wait_done", 32'(bus.done), 32'd0);
        end
        flip_ack();
        tick();
        check_val("ack_e1_done", 32'(bus.done), 32'd0);
        tick();
        check_val("ack_e2_done", 32'(bus.done), 32'd0);
        check_val("data_held", 32'(bus.xfer_data), 32'(wd));
        bus.req = '0;
        tick();
        check_val("done", 32'(bus.done), 32'd1);
        check_val("done_id", 32'(bus.done_id), 32'(w));
        check_val("busy_done", 32'(bus.busy), 32'd0);
        check_val("ack_err", 32'(bus.ack_err), 32'(exp_ack_err));
        tick();
        check_val("done_pulse", 32'(bus.done), 32'd0);
        $display("req=%b launch id=%0d data=%02h done_id=%0d", r, w, wd, bus.done_id);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        int last_cyc;
        int exp_id;
        bus.req        = '0;
        bus.req_data   = '0;
        bus.ack_toggle = 1'b0;

        // Asynchronous reset in mid-cycle
        #13 rst = 1'b1;
        #1;
        check_val("rst_grant", 32'(bus.grant), 32'd0);
        check_val("rst_xdata", 32'(bus.xfer_data), 32'd0);
        check_val("rst_xid", 32'(bus.xfer_id), 32'd0);
        check_val("rst_xtog", 32'(bus.xfer_toggle), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        check_val("rst_done_id", 32'(bus.done_id), 32'd0);
        check_val("rst_ack_err", 32'(bus.ack_err), 32'd0);
        reset_model();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("idle_busy_after_rst", 32'(bus.busy), 32'd0);
            check_val("idle_tog_after_rst", 32'(bus.xfer_toggle), 32'd0);
        end
        $display("reset/idle sequence complete");

        // Contention: all requesters held high, ack returned immediately after each launch
        bus.req      = '1;
        bus.req_data = $urandom;
        last_cyc     = 0;
        for (int n = 0; n < 5; n++) begin
            waited = 0;
            while (bus.grant == '0 && waited < 12) begin
                tick();
                waited++;
            end
            if (waited >= 12) check_val("cont_grant_timeout", 32'(waited), 32'd0);
`ifdef CDC_ARB_ROUND_ROBIN_EN
            exp_id = n % NREQ;
`else
            exp_id = 0;
`endif
            exp_tog = ~exp_tog;
            check_val("cont_grant", 32'(bus.grant), 32'(1) << exp_id);
            check_val("cont_id", 32'(bus.xfer_id), 32'(exp_id));
            check_val("cont_tog", 32'(bus.xfer_toggle), 32'(exp_tog));
            if (n > 0) check_val("cont_gap", 32'(cyc - last_cyc), 32'd4);
            $display("contention grant=%b id=%0d cyc=%0d", bus.grant, bus.xfer_id, cyc);
            last_cyc = cyc;
            rr_ptr   = exp_id;
            flip_ack();
            if (n == 4) bus.req = '0;
            tick();
        end
        tick();
        tick();
        check_val("cont_last_done", 32'(bus.done), 32'd1);
        check_val("cont_last_done_id", 32'(bus.done_id), 32'(exp_id));
        tick();

        // Single directed transfer: requester 2 with 8'hA5
        bus.req_data = $urandom;
        bus.req_data[2*DW +: DW] = 8'hA5;
        launch_and_ack(4'b0100, 4);

        // Randomized transfers
        for (int n = 0; n < 40; n++) begin
            bus.req_data = $urandom;
            launch_and_ack(NREQ'($urandom), int'($urandom_range(1, 5)));
        end

        // Spurious ack while idle
        bus.req = '0;
        flip_ack();
        tick();
        check_val("spur_e1_err", 32'(bus.ack_err), 32'd0);
        tick();
        check_val("spur_e2_err", 32'(bus.ack_err), 32'd0);
        tick();
        check_val("spur_err", 32'(bus.ack_err), 32'd1);
        check_val("spur_no_done", 32'(bus.done), 32'd0);
        exp_ack_err = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("spur_sticky", 32'(bus.ack_err), 32'd1);
            check_val("spur_no_done_later", 32'(bus.done), 32'd0);
        end
        $display("spurious ack flagged ack_err=%0d", bus.ack_err);
        bus.req_data = $urandom;
        launch_and_ack(NREQ'($urandom_range(1, 15)), 2);

        // Reset while waiting for an ack
        bus.req_data = $urandom;
        bus.req = 4'b0010;
        tick();
        exp_tog = ~exp_tog;
        check_val("mid_grant", 32'(bus.grant), 32'h2);
        check_val("mid_id", 32'(bus.xfer_id), 32'd1);
        check_val("mid_tog", 32'(bus.xfer_toggle), 32'(exp_tog));
        bus.req = '0;
        tick();
        #2 rst = 1'b1;
        #1;
        reset_model();
        check_val("mid_rst_busy", 32'(bus.busy), 32'd0);
        check_val("mid_rst_tog", 32'(bus.xfer_toggle), 32'd0);
        check_val("mid_rst_done", 32'(bus.done), 32'd0);
        check_val("mid_rst_ack_err", 32'(bus.ack_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("post_rst_done", 32'(bus.done), 32'd0);
            check_val("post_rst_busy", 32'(bus.busy), 32'd0);
        end
        $display("reset during WAIT_ACK abandoned transfer");
        bus.req_data = $urandom;
        launch_and_ack(4'b1001, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
